fetch_seq: RTL and testbench

Instruction-fetch sequencer for the 32-entry instruction memory. Owns the program counter, drives the memory's 5-bit `pc` input and captures the 32-bit `instr` it returns in the same cycle. Delivers instructions to decode through a 2-entry valid/ready buffer. Handles redirects (branch/jump) and halt-on-sentinel.

---
 rtl/fetch_seq.sv | 93 +++++++++
 tb/tb_fetch_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer with a 2-entry valid/ready output buffer
// Ports: clk/reset (sync, active-high); pc -> instruction memory, instr <- memory data (same cycle);
//        redirect_valid/redirect_pc flush and reload the PC; instr_valid/instr_ready/instr_out/instr_pc
//        present the buffer head to decode; halted flags the HALT state.
// Optional: FETCH_STATS_EN adds fetch_count, a saturating count of pushed instructions.
module fetch_seq #(
    parameter logic [4:0]  RESET_PC  = 5'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [4:0]  pc,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [4:0]  redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [4:0]  instr_pc,
`ifdef FETCH_STATS_EN
    output logic [15:0] fetch_count,
`endif
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t      r_state;
    logic [4:0]  r_pc;
    logic        r_halted;
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_buf_instr [2];
    logic [4:0]  r_buf_pc    [2];
    logic        w_pop;
    logic        w_redir;
    logic        w_push;
    logic        w_halt;
    logic        w_tail;
    assign w_pop   = (r_count != 2'd0) && instr_ready;
    assign w_redir = redirect_valid && (r_state != IDLE);
    assign w_push  = (r_state == RUN) && !redirect_valid && (instr != HALT_WORD) && ((r_count != 2'd2) || w_pop);
    assign w_halt  = (r_state == RUN) && !redirect_valid && (instr == HALT_WORD);
    // With one entry the free slot is opposite the head; when empty or full it is the head slot itself
    assign w_tail  = r_head ^ (r_count == 2'd1);
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign instr_valid = (r_count != 2'd0);
    assign instr_out   = r_buf_instr[r_head];
    assign instr_pc    = r_buf_pc[r_head];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pc           <= RESET_PC;
            r_halted       <= 1'b0;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
            r_buf_instr[0] <= 32'd0;
            r_buf_instr[1] <= 32'd0;
            r_buf_pc[0]    <= 5'd0;
            r_buf_pc[1]    <= 5'd0;
        end else if (w_redir) begin
            // Flush wins over any pop or push this cycle
            r_state  <= RUN;
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            r_head  <= r_head ^ w_pop;
            if (w_push) begin
                r_buf_instr[w_tail] <= instr;
                r_buf_pc[w_tail]    <= r_pc;
                r_pc                <= r_pc + 5'd1;
            end
            if (r_state == IDLE) begin
                r_state <= RUN;
            end else if (w_halt) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
            end
        end
    end
`ifdef FETCH_STATS_EN
    logic [15:0] r_fetch_count;
    assign fetch_count = r_fetch_count;
    always_ff @(posedge clk) begin
        if (reset)
            r_fetch_count <= 16'd0;
        else if (w_push && !w_redir && r_fetch_count != 16'hFFFF)
            r_fetch_count <= r_fetch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized + directed bench for fetch_seq against a queue-based reference model
module tb_fetch_seq;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pc;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [4:0]  instr_pc;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
`endif
    logic [31:0] mem [32];
    always #5 clk = ~clk;
    assign instr = mem[pc];
    fetch_seq dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .instr(instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
`ifdef FETCH_STATS_EN
        .fetch_count(fetch_count),
`endif
        .halted(halted)
    );
    int n_vec = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    typedef struct {
        logic [4:0]  p;
        logic [31:0] w;
    } ent_t;
    ent_t       q[$];
    logic [4:0] m_pc;
    int         m_st;
    int         m_cnt;
    task automatic cyc();
        ent_t e;
        logic [31:0] w;
        if (reset) begin
            q.delete();
            m_pc  = 5'd0;
            m_st  = 0;
            m_cnt = 0;
        end else if (redirect_valid && m_st != 0) begin
            q.delete();
            m_pc = redirect_pc;
            m_st = 1;
        end else begin
            if (q.size() > 0 && instr_ready) q.delete(0);
            if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                w = mem[m_pc];
                if (w == HALT) begin
                    m_st = 2;
                end else if (q.size() < 2) begin
                    e.p = m_pc;
                    e.w = w;
                    q.push_back(e);
                    m_pc = m_pc + 5'd1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("instr_out", instr_out, q[0].w);
            check("instr_pc", {27'd0, instr_pc}, {27'd0, q[0].p});
        end
        check("pc", {27'd0, pc}, {27'd0, m_pc});
        check("halted", {31'd0, halted}, {31'd0, m_st == 2});
`ifdef FETCH_STATS_EN
        check("fetch_count", {16'd0, fetch_count}, m_cnt);
`endif
    endtask
    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask
    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom & 32'h7FFFFFFF;
        mem[0] = 32'h00000200;
        mem[1] = 32'h00000201;
        mem[2] = 32'h00000204;
        mem[3] = 32'h00000108;
        cyc();
        cyc();
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_instr_pc", {27'd0, instr_pc}, 32'd0);
        reset       = 1'b0;
        instr_ready = 1'b1;
        cyc();
        check("lat_edge1", {31'd0, instr_valid}, 32'd0);
        cyc();
        check("s1_out0", instr_out, 32'h00000200);
        cyc();
        check("s1_out1", instr_out, 32'h00000201);
        cyc();
        check("s1_out2", instr_out, 32'h00000204);
        cyc();
        check("s1_out3", instr_out, 32'h00000108);
        check("s1_pc3", {27'd0, instr_pc}, 32'd3);
`ifdef FETCH_STATS_EN
        check("s1_count", {16'd0, fetch_count}, 32'd4);
`endif
        do_reset();
        instr_ready = 1'b0;
        cyc();
        cyc();
        repeat (5) cyc();
        check("s2_hold_out", instr_out, 32'h00000200);
        check("s2_pc_stop", {27'd0, pc}, 32'd2);
        instr_ready = 1'b1;
        repeat (6) cyc();
        do_reset();
        instr_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check("s3_head1", {27'd0, instr_pc}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 5'd5;
        cyc();
        redirect_valid = 1'b0;
        check("s3_gap", {31'd0, instr_valid}, 32'd0);
        cyc();
        check("s3_pc5", {27'd0, instr_pc}, 32'd5);
        check("s3_mem5", instr_out, mem[5]);
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        cyc();
        redirect_valid = 1'b0;
        repeat (5) cyc();
        mem[4] = HALT;
        do_reset();
        repeat (10) cyc();
        check("s5_halted", {31'd0, halted}, 32'd1);
        check("s5_pc4", {27'd0, pc}, 32'd4);
        check("s5_drained", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 5'd0;
        cyc();
        redirect_valid = 1'b0;
        check("s5_resume", {31'd0, halted}, 32'd0);
        repeat (3) cyc();
        instr_ready = 1'b0;
        repeat (6) cyc();
        check("s6_full", {31'd0, instr_valid}, 32'd1);
        do_reset();
        check("s6_valid", {31'd0, instr_valid}, 32'd0);
        check("s6_pc", {27'd0, pc}, 32'd0);
        check("s6_halted", {31'd0, halted}, 32'd0);
        mem[4] = $urandom & 32'h7FFFFFFF;
        repeat (3000) begin
            instr_ready    = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_pc    = 5'($urandom);
            reset          = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 9) == 0)
                mem[$urandom_range(0, 31)] = ($urandom_range(0, 5) == 0) ? HALT : ($urandom & 32'h7FFFFFFF);
            cyc();
        end
        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
